// File: rtl/cmult_rr_scheduler_if.sv
// Requester, shared-multiplier and response bundle for the complex multiplier scheduler.
// slave is the scheduler side; master is the requesters/multiplier side.
interface cmult_rr_scheduler_if #(
    parameter int W     = 20,
    parameter int N_REQ = 4,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a_i;
    logic [N_REQ*W-1:0] req_a_q;
    logic [N_REQ*W-1:0] req_b_i;
    logic [N_REQ*W-1:0] req_b_q;
    logic [W-1:0]       mult_a_i;
    logic [W-1:0]       mult_a_q;
    logic [W-1:0]       mult_b_i;
    logic [W-1:0]       mult_b_q;
    logic [W-1:0]       mult_out_i;
    logic [W-1:0]       mult_out_q;
    logic               resp_valid;
    logic [IDW-1:0]     resp_id;
    logic [W-1:0]       resp_i;
    logic [W-1:0]       resp_q;

    modport slave (
        input  req_valid, req_a_i, req_a_q, req_b_i, req_b_q, mult_out_i, mult_out_q,
        output req_ready, mult_a_i, mult_a_q, mult_b_i, mult_b_q,
        output resp_valid, resp_id, resp_i, resp_q
    );

    modport master (
        output req_valid, req_a_i, req_a_q, req_b_i, req_b_q, mult_out_i, mult_out_q,
        input  req_ready, mult_a_i, mult_a_q, mult_b_i, mult_b_q,
        input  resp_valid, resp_id, resp_i, resp_q
    );
endinterface

// File: rtl/cmult_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined complex multiplier among N_REQ requesters;
// a {valid,id} tag pipe tracks each op through the multiplier and labels its result.
module cmult_rr_scheduler #(
    parameter int W        = 20,
    parameter int N_REQ    = 4,
    parameter int IDW      = 2,
    parameter int MULT_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    cmult_rr_scheduler_if.slave  bus,
    output logic [IDW+1:0]       inflight
);
    localparam int STAGES = 1 + MULT_LAT;
    localparam logic [IDW+1:0] INF_MAX = (IDW + 2)'(STAGES);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   ptr_next;
    logic             grant_found;
    logic             handshake;
    logic [N_REQ-1:0] ready;
    logic [W-1:0]     a_i_r, a_q_r, b_i_r, b_q_r;
    logic [STAGES-1:0] tag_v;
    logic [IDW-1:0]   tag_id [STAGES];

    // Handshake: requester k transfers when req_valid[k] & req_ready[k] in the same cycle.
    // Ready is offered to the first valid requester at or after ptr, so valid may be raised
    // without waiting for ready, and may be dropped before ready without side effects.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        ready       = '0;
        for (int j = 0; j < N_REQ; j++) begin
            int k;
            k = (int'(ptr) + j) % N_REQ;
            if (!grant_found && bus.req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(k);
            end
        end
        if (en && !reset && grant_found) ready[grant_idx] = 1'b1;
    end

    assign handshake     = en && !reset && grant_found;
    assign ptr_next      = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign bus.req_ready = ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            a_i_r    <= '0;
            a_q_r    <= '0;
            b_i_r    <= '0;
            b_q_r    <= '0;
            tag_v    <= '0;
            inflight <= '0;
            for (int s = 0; s < STAGES; s++) tag_id[s] <= '0;
        end else begin
            if (handshake) begin
                ptr   <= ptr_next;
                a_i_r <= bus.req_a_i[grant_idx*W +: W];
                a_q_r <= bus.req_a_q[grant_idx*W +: W];
                b_i_r <= bus.req_b_i[grant_idx*W +: W];
                b_q_r <= bus.req_b_q[grant_idx*W +: W];
            end
            tag_v <= {tag_v[STAGES-2:0], handshake};
            for (int s = STAGES - 1; s > 0; s--) tag_id[s] <= tag_id[s-1];
            tag_id[0] <= grant_idx;
            if (handshake && !tag_v[STAGES-1]) begin
                if (inflight != INF_MAX) inflight <= inflight + 1'b1;
            end else if (!handshake && tag_v[STAGES-1]) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

    assign bus.mult_a_i = a_i_r;
    assign bus.mult_a_q = a_q_r;
    assign bus.mult_b_i = b_i_r;
    assign bus.mult_b_q = b_q_r;

    // Masked during reset so an op reaching the last stage in the reset cycle is dropped too.
    assign bus.resp_valid = tag_v[STAGES-1] & ~reset;
    assign bus.resp_id    = tag_id[STAGES-1];
    assign bus.resp_i     = bus.mult_out_i;
    assign bus.resp_q     = bus.mult_out_q;
endmodule
